// File: rtl/bound_flasher_pkg.sv
// bound_flasher_pkg: shared phase encoding, lamp-bar constants and decode helpers
package bound_flasher_pkg;
  localparam int LED_W = 16;
  localparam logic [4:0] UP1_MAX = 5'd6;
  localparam logic [4:0] UP2_MAX = 5'd11;
  localparam logic [4:0] UP3_MAX = 5'd16;
  localparam logic [4:0] DN2_MIN = 5'd5;
  // UPx is always followed by its DNx, so the ordering matters
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    UP1  = 3'd1,
    DN1  = 3'd2,
    UP2  = 3'd3,
    DN2  = 3'd4,
    UP3  = 3'd5,
    DN3  = 3'd6
  } phase_t;
  function automatic logic [4:0] up_max(phase_t ph);
    return ph == UP1 ? UP1_MAX : ph == UP2 ? UP2_MAX : UP3_MAX;
  endfunction
  function automatic logic [LED_W-1:0] therm(logic [4:0] n);
    logic [LED_W:0] t;
    t = ({{LED_W{1'b0}}, 1'b1} << n) - {{LED_W{1'b0}}, 1'b1};
    return t[LED_W-1:0];
  endfunction
endpackage

// File: rtl/bound_flasher_flick_capture.sv
// flick_capture: catches short flick pulses with a flick-clocked toggle and flags one event per clk edge
module flick_capture (
  input  logic clk,
  input  logic rst_n,
  input  logic flick,
  output logic flick_evt
);
  logic tog, tog_q;
  always_ff @(posedge flick or negedge rst_n)
    if (!rst_n) tog <= 1'b0;
    else tog <= ~tog;
  // copy follows every edge, so a captured pulse is seen exactly once
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) tog_q <= 1'b0;
    else tog_q <= tog;
  assign flick_evt = (tog ^ tog_q) | flick;
endmodule

// File: rtl/bound_flasher.sv
// bound_flasher: three-bounce thermometer lamp bar with flick start and dwell-point kickback
module bound_flasher
  import bound_flasher_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flick,
  output logic [LED_W-1:0] LED
);
  phase_t ph, ph_nxt;
  logic [4:0] n, n_nxt;
  logic evt;
  flick_capture u_cap (
    .clk(clk),
    .rst_n(rst_n),
    .flick(flick),
    .flick_evt(evt)
  );
  always_comb begin
    ph_nxt = ph;
    n_nxt = n;
    unique case (ph)
      IDLE: begin
        ph_nxt = evt ? UP1 : IDLE;
        n_nxt = evt ? 5'd1 : 5'd0;
      end
      UP1, UP2, UP3: begin
        ph_nxt = n == up_max(ph) ? phase_t'(ph + 3'd1) : ph;
        n_nxt = n == up_max(ph) ? n - 5'd1 : n + 5'd1;
      end
      DN1: begin
        ph_nxt = n == 5'd0 ? (evt ? UP1 : UP2) : DN1;
        n_nxt = n == 5'd0 ? 5'd1 : n - 5'd1;
      end
      DN2: begin
        ph_nxt = n == DN2_MIN ? (evt ? UP2 : UP3) : DN2;
        n_nxt = n == DN2_MIN ? n + 5'd1 : n - 5'd1;
      end
      DN3: begin
        ph_nxt = n == 5'd0 ? IDLE : DN3;
        n_nxt = n == 5'd0 ? 5'd0 : n - 5'd1;
      end
      default: begin
        ph_nxt = IDLE;
        n_nxt = 5'd0;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ph <= IDLE;
      n <= 5'd0;
      LED <= '0;
    end else begin
      ph <= ph_nxt;
      n <= n_nxt;
      LED <= therm(n_nxt);
    end
endmodule

// File: tb/tb_bound_flasher.sv
// tb_bound_flasher: directed and random flick/reset stimulus checked against a segment-list lamp model
module tb_bound_flasher;
  logic clk = 1'b0, rst_n = 1'b0, flick = 1'b0;
  logic [15:0] LED;
  int n_chk = 0, n_fail = 0;
  int mn = 0, mk = 0, hold_left = 0;
  bit rose = 1'b0;
  // segment k runs toward tgt[k]; odd k climb, even k descend, k=0 is idle
  int tgt[7] = '{0, 6, 0, 11, 5, 16, 0};

  bound_flasher dut (
    .clk(clk),
    .rst_n(rst_n),
    .flick(flick),
    .LED(LED)
  );

  always #10 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(string tag, logic [15:0] got, logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] bar(int n);
    for (int i = 0; i < 16; i++) bar[i] = i < n;
  endfunction

  task automatic step_model(bit evt);
    if (mk == 0) begin
      if (evt) begin
        mk = 1;
        mn = 1;
      end
    end else if (mn != tgt[mk]) mn += (mk % 2) ? 1 : -1;
    else if (mk % 2) begin
      mk++;
      mn--;
    end else if (mk == 6) begin
      mk = 0;
      mn = 0;
    end else begin
      mk = evt ? mk - 1 : mk + 1;
      mn++;
    end
  endtask

  task automatic tick(string tag, bit pulse = 1'b0, bit hi = 1'b0);
    @(negedge clk);
    if (hi && !flick) rose = 1'b1;
    flick = hi;
    if (pulse && !hi) begin
      #2 flick = 1'b1;
      rose = 1'b1;
      #4 flick = 1'b0;
    end
    @(posedge clk);
    step_model(rose | flick);
    rose = 1'b0;
    #1 check(tag, LED, bar(mn));
  endtask

  task automatic run_to(string tag, int k, int n);
    int i = 0;
    while (!(mk == k && mn == n) && i < 200) begin
      tick(tag);
      i++;
    end
    check({tag, "_reach"}, LED, bar(n));
  endtask

  task automatic do_reset();
    @(negedge clk);
    #3 rst_n = 1'b0;
    flick = 1'b0;
    hold_left = 0;
    mk = 0;
    mn = 0;
    rose = 1'b0;
    #1 check("async_rst", LED, 16'h0000);
    #2 flick = 1'b1;
    #2 flick = 1'b0;
    repeat (5) @(posedge clk);
    #3 flick = 1'b1;
    #4 flick = 1'b0;
    check("rst_hold", LED, 16'h0000);
    @(negedge clk) rst_n = 1'b1;
    tick("rst_release");
  endtask

  initial begin
    @(negedge clk);
    check("reset", LED, 16'h0000);
    rst_n = 1'b1;
    tick("idle");
    tick("start", 1'b1);
    repeat (70) tick("walk");
    tick("restart", 1'b1);
    run_to("to_dn2", 4, 5);
    tick("dn2_kick", 1'b1);
    run_to("dn2_again", 4, 5);
    repeat (3) tick("dn2_hold", 1'b0, 1'b1);
    repeat (8) tick("after_hold");
    run_to("to_dn3", 6, 0);
    tick("dn3_flick", 1'b1);
    repeat (3) tick("dn3_idle");
    tick("start2", 1'b1);
    run_to("to_dn1", 2, 0);
    tick("dn1_kick", 1'b1);
    run_to("up1_peak", 1, 6);
    run_to("mid_dn1", 2, 3);
    tick("mid_dn_flick", 1'b1);
    run_to("mid_up2", 3, 8);
    tick("mid_up_flick", 1'b1);
    check("up2_1ff", LED, 16'h01FF);
    do_reset();
    tick("start3", 1'b1);
    repeat (5) tick("pre_coinc");
    @(posedge clk);
    rst_n = 1'b0;
    flick = 1'b1;
    mk = 0;
    mn = 0;
    rose = 1'b0;
    #1 check("coinc_rst", LED, 16'h0000);
    #5 flick = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    tick("post_coinc");
    tick("coinc_start", 1'b1);
    check("coinc_start_val", LED, 16'h0001);
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = $urandom_range(0, 199);
      if (hold_left > 0) begin
        tick("rnd_hold", 1'b0, 1'b1);
        hold_left--;
      end else if (r < 12) tick("rnd_pulse", 1'b1);
      else if (r < 16) begin
        hold_left = $urandom_range(0, 3);
        tick("rnd_hold", 1'b0, 1'b1);
      end else if (r == 199) do_reset();
      else tick("rnd");
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/bound_flasher.md
BOUND_FLASHER -- requirements
Module: bound_flasher

Interface
REQ-001 Ports: one clock; reset is asynchronous and active-low (clk, rst_n); polarity and synchronicity are fixed.
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 flick  input  1  asynchronous start/kickback request; pulses may be shorter than one clk period and need not span a clk edge.
REQ-005 LED  output  16  thermometer lamp bar; LED[i]=1 iff i < n, where n (0..16) is the lit count.
REQ-006 No parameters; width is fixed at 16 lamps.

Function
REQ-007 Flick event: a rising edge of flick toggles a capture flop (clocked by flick, async-cleared by rst_n); in the clk domain an event is pending when the toggle differs from its registered copy, OR'ed with flick sampled high at the edge.
REQ-008 The registered copy updates every clk edge, so each event is consumed or discarded at the first edge after it; a held-high flick counts as one event per edge it covers.
REQ-009 Phases (3-bit state) with lit-count targets: IDLE; UP1 (to 6); DN1 (to 0); UP2 (to 11); DN2 (to 5); UP3 (to 16); DN3 (to 0).
REQ-010 IDLE: n=0; a pending event moves to UP1 with n=1 at the same edge; otherwise IDLE is held.
REQ-011 UPx: n increments by 1 per edge; at the edge where n equals the phase target, the phase changes to the following DNx with n=target-1, so the peak is held one cycle.
REQ-012 DNx: n decrements by 1 per edge; at the edge where n equals the phase minimum (dwell cycle), the next phase is decided.
REQ-013 DN1 at n=0: a pending event kicks back to UP1 with n=1; otherwise the phase goes to UP2 with n=1.
REQ-014 DN2 at n=5: a pending event kicks back to UP2 with n=6; otherwise the phase goes to UP3 with n=6.
REQ-015 DN3 at n=0: the phase goes to IDLE unconditionally, so no kickback occurs on the final step; an event at that edge is discarded.
REQ-016 Events in any UP phase, or in a DN phase before its minimum, are discarded with no effect.
REQ-017 LED is a registered decode of n with no combinational path from flick to LED.
REQ-018 Arithmetic: n is 5 bits unsigned and never leaves the range 0..16.

Reset
REQ-019 rst_n low immediately forces LED=0x0000, n=0, phase=IDLE, and clears the capture toggle and its registered copy.
REQ-020 flick edges while rst_n is low are ignored, including a flick coincident with reset assertion; after release a new flick is required to start.
REQ-021 Reset mid-operation (any phase) aborts the sequence with no resumption.

Structure
REQ-022 A shared package bound_flasher_pkg holds the phase enum and the constants LED_W=16, UP1_MAX=6, UP2_MAX=11, UP3_MAX=16, DN2_MIN=5.
REQ-023 One sub-module, flick_capture, holds the flick-clocked toggle flop and the clk-domain pending detection, and outputs a one-bit flick_evt.
REQ-024 The top level holds the phase/count FSM and the LED decode.

Verification
REQ-025 Release reset, then a 4 ns flick between clk edges -> LED walks 0x0001..0x003F, down to 0x0000, up to 0x07FF, down to 0x001F, up to 0xFFFF, down to 0x0000, then stays 0x0000.
REQ-026 Flick during the DN2 dwell (LED=0x001F) -> LED rises 0x003F..0x07FF again, then DN2 repeats; a 50 ns held flick gives the same single kickback.
REQ-027 Flick during the DN1 dwell (LED=0x0000 after 0x0001) -> LED restarts at 0x0001 and climbs to 0x003F; a flick in mid-UP or mid-DN (e.g. LED=0x00FF) -> sequence unchanged.
REQ-028 Flick during the final DN3 dwell -> LED=0x0000 and IDLE; no restart without a new flick.
REQ-029 rst_n low during UP2 (e.g. LED=0x01FF) -> LED=0x0000 asynchronously, before the next edge; flick asserted with rst_n low, or 100 ns after reset assertion -> LED stays 0x0000.
REQ-030 Flick and rst_n low at the same clk edge -> reset wins, LED=0x0000; a flick after release -> normal start at 0x0001.
